// File: rtl/pwm_duty_ramp_if.sv
// Command/status bundle between the j1 CPU register block and the duty ramp.
//
// Handshake: every wr_* line is a one-cycle write strobe with no ready and no
// back-pressure. The payload (target_in, rate_in or step_in) must be valid in
// the same cycle as its strobe, and it is captured on that rising clk edge.
// estop is a level, not a strobe. duty, busy, at_target and state_dbg are
// registered and change together on the same edge.
interface pwm_duty_ramp_if #(
  parameter int L  = 10,
  parameter int RW = 16
) ();
  logic          wr_target;
  logic [L-1:0]  target_in;
  logic          wr_rate;
  logic [RW-1:0] rate_in;
  logic          wr_step;
  logic [L-1:0]  step_in;
  logic          estop;
  logic [L-1:0]  duty;
  logic          busy;
  logic          at_target;
  logic [1:0]    state_dbg;

  modport master (
    output wr_target, target_in, wr_rate, rate_in, wr_step, step_in, estop,
    input  duty, busy, at_target, state_dbg
  );

  modport slave (
    input  wr_target, target_in, wr_rate, rate_in, wr_step, step_in, estop,
    output duty, busy, at_target, state_dbg
  );
endinterface

// File: rtl/pwm_duty_ramp.sv
// Slew-rate limiter in front of the motor PWM generator. The duty output moves
// toward the CPU-written target by step_q every rate_q clocks, and estop forces
// the duty to zero on the next edge.
module pwm_duty_ramp #(
  parameter int L        = 10,
  parameter int RW       = 16,
  parameter int RATE_RST = 1000
) (
  input  logic           clk,
  input  logic           rst,
  pwm_duty_ramp_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    STOP = 2'd3
  } state_t;

  state_t        state;
  logic [L-1:0]  duty;
  logic [L-1:0]  target_q;
  logic [L-1:0]  step_q;
  logic [RW-1:0] rate_q;
  logic [RW-1:0] tick;
  logic          busy;
  logic          at_target;

  logic [L:0]    up_sum;
  logic          up_hit;
  logic          dn_hit;
  logic [RW:0]   tick_nx;
  logic          step_due;
  logic [RW-1:0] rate_eff;
  logic [L-1:0]  step_eff;

  // Step arithmetic and interval check. The up sum carries an extra bit so a
  // large step near full scale clamps to the target instead of wrapping.
  // A rate of zero makes every edge a step edge.
  always_comb begin
    up_sum   = {1'b0, duty} + {1'b0, step_q};
    up_hit   = (up_sum >= {1'b0, target_q});
    dn_hit   = (step_q > duty) || ((duty - step_q) <= target_q);
    tick_nx  = {1'b0, tick} + {{RW{1'b0}}, 1'b1};
    step_due = (tick_nx >= {1'b0, rate_q});
    rate_eff = bus.wr_rate ? bus.rate_in : rate_q;
    step_eff = (bus.step_in == '0) ? L'(1) : bus.step_in;
  end

  // Ramp FSM with config registers and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty      <= '0;
      target_q  <= '0;
      rate_q    <= RW'(RATE_RST);
      step_q    <= L'(1);
      tick      <= '0;
      state     <= IDLE;
      busy      <= 1'b0;
      at_target <= 1'b1;
    end else begin
      if (bus.wr_rate) rate_q <= bus.rate_in;
      if (bus.wr_step) step_q <= step_eff;

      if (bus.estop) begin
        duty      <= '0;
        target_q  <= '0;
        tick      <= '0;
        state     <= STOP;
        busy      <= 1'b0;
        at_target <= 1'b0;
      end else if (bus.wr_target) begin
        target_q <= bus.target_in;
        tick     <= '0;
        if (rate_eff == '0 || bus.target_in == duty) begin
          duty      <= bus.target_in;
          state     <= IDLE;
          busy      <= 1'b0;
          at_target <= 1'b1;
        end else begin
          state     <= (bus.target_in > duty) ? UP : DOWN;
          busy      <= 1'b1;
          at_target <= 1'b0;
        end
      end else begin
        case (state)
          UP, DOWN: begin
            if (step_due) begin
              tick <= '0;
              if ((state == UP) ? up_hit : dn_hit) begin
                duty      <= target_q;
                state     <= IDLE;
                busy      <= 1'b0;
                at_target <= 1'b1;
              end else begin
                duty <= (state == UP) ? up_sum[L-1:0] : (duty - step_q);
              end
            end else begin
              tick <= tick_nx[RW-1:0];
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.duty      = duty;
  assign bus.busy      = busy;
  assign bus.at_target = at_target;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed bench for pwm_duty_ramp. Each directed step queues the status
// expected after each upcoming clock edge; the checker pops one entry per edge.
module tb_pwm_duty_ramp;
  localparam int L  = 10;
  localparam int RW = 16;
  localparam int W  = L + 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_UP   = 2'd1;
  localparam logic [1:0] S_DN   = 2'd2;
  localparam logic [1:0] S_STOP = 2'd3;

  logic clk = 1'b0;
  logic rst;

  pwm_duty_ramp_if #(.L(L), .RW(RW)) bus ();

  pwm_duty_ramp #(.L(L), .RW(RW), .RATE_RST(1000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic push_e(input logic [1:0] st, input logic [L-1:0] d);
    logic b;
    logic a;
    b = (st == S_UP) || (st == S_DN);
    a = (st == S_IDLE);
    exp_q.push_back({st, b, a, d});
  endtask

  task automatic push_n(input int n, input logic [1:0] st, input logic [L-1:0] d);
    for (int i = 0; i < n; i++) push_e(st, d);
  endtask

  // One clock edge: sample #1 after it, drop strobes, compare against queue head.
  task automatic step_check(input string tag);
    logic [W-1:0] got;
    logic [W-1:0] exp;
    @(posedge clk);
    #1;
    bus.wr_target = 1'b0;
    bus.wr_rate   = 1'b0;
    bus.wr_step   = 1'b0;
    got = {bus.state_dbg, bus.busy, bus.at_target, bus.duty};
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $error("FAIL %s: got st=%0d duty=%0d with no expected entry queued", tag, got[W-1:W-2], got[L-1:0]);
    end else begin
      exp = exp_q.pop_front();
      assert (got === exp) else begin
        n_bad++;
        $error("FAIL %s: got st=%0d busy=%0b at=%0b duty=%0d, exp st=%0d busy=%0b at=%0b duty=%0d",
               tag, got[W-1:W-2], got[L+1], got[L], got[L-1:0],
               exp[W-1:W-2], exp[L+1], exp[L], exp[L-1:0]);
      end
    end
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) step_check(tag);
  endtask

  // driver tasks
  task automatic wr_tgt(input logic [L-1:0] v);
    bus.wr_target = 1'b1;
    bus.target_in = v;
  endtask

  task automatic wr_rate(input logic [RW-1:0] v);
    bus.wr_rate = 1'b1;
    bus.rate_in = v;
  endtask

  task automatic wr_step(input logic [L-1:0] v);
    bus.wr_step = 1'b1;
    bus.step_in = v;
  endtask

  initial begin
    rst           = 1'b1;
    bus.wr_target = 1'b0;
    bus.target_in = '0;
    bus.wr_rate   = 1'b0;
    bus.rate_in   = '0;
    bus.wr_step   = 1'b0;
    bus.step_in   = '0;
    bus.estop     = 1'b0;

    // reset state
    push_n(2, S_IDLE, 0);
    drain("reset");
    rst = 1'b0;

    // basic ramp 0 -> 50, rate 4, step 10
    wr_rate(4); wr_step(10);
    push_e(S_IDLE, 0);
    step_check("t1_cfg");
    wr_tgt(50);
    push_e(S_UP, 0);
    for (int s = 1; s <= 5; s++) begin
      push_n(3, S_UP, L'(10 * (s - 1)));
      push_e((s == 5) ? S_IDLE : S_UP, L'(10 * s));
    end
    push_e(S_IDLE, 50);
    drain("t1_ramp");

    // clamp at target: 0 -> 70 step 30
    wr_rate(0); wr_tgt(0);
    push_e(S_IDLE, 0);
    step_check("t2_jump0");
    wr_rate(1); wr_step(30);
    push_e(S_IDLE, 0);
    step_check("t2_cfg");
    wr_tgt(70);
    push_e(S_UP, 0); push_e(S_UP, 30); push_e(S_UP, 60);
    push_e(S_IDLE, 70); push_e(S_IDLE, 70);
    drain("t2_clamp");

    // ramp down 25 -> 0, no underflow
    wr_rate(0); wr_tgt(25);
    push_e(S_IDLE, 25);
    step_check("t3_jump25");
    wr_rate(1); wr_step(10);
    push_e(S_IDLE, 25);
    step_check("t3_cfg");
    wr_tgt(0);
    push_e(S_DN, 25); push_e(S_DN, 15); push_e(S_DN, 5);
    push_e(S_IDLE, 0); push_e(S_IDLE, 0);
    drain("t3_down");

    // retarget mid-ramp: 0 -> 200, then 20 at duty 60
    wr_rate(2);
    push_e(S_IDLE, 0);
    step_check("t4_cfg");
    wr_tgt(200);
    push_n(2, S_UP, 0);
    for (int v = 10; v <= 50; v += 10) push_n(2, S_UP, L'(v));
    push_e(S_UP, 60);
    drain("t4_up");
    wr_tgt(20);
    push_n(2, S_DN, 60);
    push_n(2, S_DN, 50);
    push_n(2, S_DN, 40);
    push_n(2, S_DN, 30);
    push_e(S_IDLE, 20);
    drain("t4_retarget");

    // rate 0 jump to full scale, then L+1-bit clamp near full scale
    wr_rate(0); wr_tgt(1023);
    push_e(S_IDLE, 1023);
    step_check("t6_jump1023");
    wr_tgt(1000);
    push_e(S_IDLE, 1000);
    step_check("t6_jump1000");
    wr_rate(1); wr_step(100);
    push_e(S_IDLE, 1000);
    step_check("t6_cfg");
    wr_tgt(1023);
    push_e(S_UP, 1000); push_e(S_IDLE, 1023);
    drain("t6_fullscale");

    // rate change mid-ramp with tick already past the new interval
    wr_rate(10);
    push_e(S_IDLE, 1023);
    step_check("t7_cfg");
    wr_tgt(0);
    push_n(6, S_DN, 1023);
    drain("t7_wait");
    wr_rate(3);
    push_e(S_DN, 1023);
    step_check("t7_rate_edge");
    push_e(S_DN, 923); push_n(2, S_DN, 923); push_e(S_DN, 823);
    drain("t7_new_rate");

    // emergency stop
    wr_rate(0); wr_tgt(500);
    push_e(S_IDLE, 500);
    step_check("t5_jump500");
    wr_rate(3);
    push_e(S_IDLE, 500);
    step_check("t5_cfg");
    wr_tgt(600);
    push_e(S_UP, 500);
    step_check("t5_ramp");
    bus.estop = 1'b1;
    push_e(S_STOP, 0);
    step_check("t5_estop");
    wr_tgt(300); wr_step(0);
    push_e(S_STOP, 0);
    step_check("t5_estop_ignore");
    bus.estop = 1'b0;
    push_n(2, S_STOP, 0);
    drain("t5_stop_hold");
    wr_tgt(100);
    push_e(S_UP, 0); push_n(2, S_UP, 0);
    push_n(3, S_UP, 1); push_e(S_UP, 2);
    drain("t5_resume_step1");

    // reset mid-ramp with estop high, then default rate of 1000
    rst = 1'b1;
    bus.estop = 1'b1;
    push_e(S_IDLE, 0);
    step_check("t8_rst_mid");
    rst = 1'b0;
    bus.estop = 1'b0;
    push_e(S_IDLE, 0);
    step_check("t8_post_rst");
    wr_tgt(5);
    push_e(S_UP, 0);
    push_n(999, S_UP, 0);
    push_e(S_UP, 1);
    drain("t8_rate_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pwm_duty_ramp.md
Name: pwm_duty_ramp

Overview:
- Slew-rate limiter that sits directly upstream of the motor PWM generator in the Position subsystem.
- Takes a target duty written by the j1 CPU and moves its duty output toward that target in fixed steps at a programmable interval. This prevents current spikes on the drive motors.
- The duty output drives the PWM generator's number input directly.
- Provides an emergency-stop path that forces duty to zero immediately.

Parameters:
- L, 10, width of duty, target and step values (matches the PWM generator's number width).
- RW, 16, width of the step-interval register.
- RATE_RST, 1000, reset value of the step-interval register, in clk cycles.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- wr_target  input  1  one-cycle strobe; loads target_in.
- target_in  input  L  requested duty.
- wr_rate  input  1  one-cycle strobe; loads rate_in.
- rate_in  input  RW  clk cycles between steps.
- wr_step  input  1  one-cycle strobe; loads step_in.
- step_in  input  L  duty increment per step.
- estop  input  1  level; emergency stop.
- duty  output  L  current duty, feeds the PWM generator's number input.
- busy  output  1  high while ramping.
- at_target  output  1  high when duty equals target and not in STOP.

Behaviour:
- Reset, evaluated on the clk edge while rst=1:
  - duty=0, target_q=0, rate_q=RATE_RST, step_q=1, tick=0.
  - state=IDLE, busy=0, at_target=1.
- Registers:
  - target_q, rate_q, step_q load on the edge where their strobe is high.
  - step_in=0 is stored as 1.
- States: IDLE, UP, DOWN, STOP.
- On wr_target at edge k (estop low):
  - target_q<=target_in and tick<=0.
  - Next state: UP if target_in>duty, DOWN if target_in<duty, IDLE if equal.
  - If rate_q==0, duty<=target_in at edge k and state=IDLE (immediate jump, no ramp).
- In UP or DOWN, on each edge:
  - If tick>=rate_q-1: apply one step and set tick<=0.
  - Otherwise tick<=tick+1.
  - The first duty change is therefore visible rate_q cycles after the wr_target edge.
- UP step:
  - duty<=min(duty+step_q, target_q).
  - Compute the sum at L+1 bits; no wrap past 2^L-1.
- DOWN step:
  - duty<=max(duty-step_q, target_q).
  - If step_q>duty, clamp to target_q; no underflow.
- When a step makes duty==target_q, the state goes to IDLE on that same edge.
- New wr_target mid-ramp:
  - Direction is re-evaluated against the current duty and tick is cleared.
  - duty itself is not changed on that edge.
- wr_rate mid-ramp:
  - New rate applies immediately and tick is not cleared.
  - If tick>=new rate_q-1, the step occurs on the next edge.
- wr_step mid-ramp: applies from the next step.
- estop=1 in any state, highest priority after rst:
  - On the next edge: duty<=0, target_q<=0, tick<=0, state<=STOP.
  - wr_target while estop is high is ignored; wr_rate and wr_step still load.
- STOP:
  - duty is held at 0.
  - The block leaves STOP only on a wr_target with estop low, which is handled as a normal wr_target from duty=0.
  - estop deassertion alone stays in STOP.
- Outputs:
  - busy is high exactly in UP or DOWN.
  - at_target = (state==IDLE).
  - Both are registered and consistent with duty on the same edge.
- Simultaneous wr_target and wr_rate on the same edge: the new rate_in is used for both the jump decision and the tick comparison.
- rst asserted mid-ramp: all reset values apply on that edge, regardless of estop.

Test Plan:
- Reset, then rate=4, step=10, write target=50 → duty goes 0,10,20,30,40,50 at edges k+4, k+8, …, k+20. busy is high until duty=50; then at_target=1.
- Clamp at target: duty=0, step=30, target=70 → duty 30, 60, 70 (last step clamped), then IDLE.
- Ramp down with no underflow: duty=25, step=10, target=0, rate=1 → duty 15, 5, 0 on consecutive edges; never wraps to 1023.
- Retarget mid-ramp: ramp 0→200 with step=10, rate=2; write target=20 when duty=60 → state DOWN, then duty 50, 40, 30, 20.
- Emergency stop: estop pulsed while duty=500 → duty=0 on the next edge, state STOP. A wr_target during estop is ignored. After estop drops, write target=100 → ramp resumes from 0.
- rate=0 jump and full-scale boundary: write target=1023 → duty=1023 on the next edge, at_target=1. Write step=0 → step_q=1. Apply rst mid-ramp → duty=0, rate_q=1000.
